clk_step_ctrl: RTL and testbench

Parametrised successor to the fixed 50M-count slow-clock toggler that drives the pipelined processors. It generates the processor clock from clkin with a runtime-loadable divide ratio and three modes: free-run, halt and single-step from a debounced board key. It also provides a one-cycle tick on each processor rising edge and a processor-cycle counter for LED display. It sits at top level between the board clock/keys and the dual-issue pipeline and memories.

---
 rtl/clk_step_ctrl_pkg.sv | 21 ++
 rtl/clk_step_ctrl_debounce.sv | 57 +++++
 rtl/clk_step_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_step_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_step_ctrl_pkg
// Purpose  : Mode and FSM state encodings shared by the processor clock controller.
// Revision : 1.0
// ============================================================================
package clk_step_ctrl_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP_HI = 2'd2,
        ST_STEP_LO = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_step_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Synchronises and debounces a raw key; one-cycle pulse on press.
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic pulse
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_MAX = DW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[0], key_in};
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        // Any cycle agreeing with the accepted level restarts the qualification count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
                pulse_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_step_ctrl
// Purpose  : Processor clock generator with runtime divide, run/halt/single-step.
// Revision : 1.0
// ============================================================================
module clk_step_ctrl
    import clk_step_ctrl_pkg::*;
#(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 49999999,
    parameter int DEB_CYCLES  = 500000,
    parameter int CYC_W       = 16
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [1:0]       mode_sel,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             step_key,
    input  logic             cnt_clr,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CYC_W-1:0] edge_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [CYC_W-1:0] edge_count_q, edge_count_d;
    logic             step_pulse;
    logic             toggle;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk    (clkin),
        .rst    (reset),
        .key_in (step_key),
        .pulse  (step_pulse)
    );

    assign toggle = (state_q != ST_IDLE) && (counter_q == '0);

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        // A reload this cycle still sees the old ratio; the new one takes effect next reload.
        div_d     = div_load ? div_val : div_q;

        case (state_q)
            ST_IDLE: begin
                clk_out_d = 1'b0;
                case (mode_sel)
                    MODE_RUN: begin
                        counter_d = div_q;
                        state_d   = ST_RUN;
                    end
                    MODE_STEP: begin
                        if (step_pulse) begin
                            clk_out_d = 1'b1;
                            tick_d    = 1'b1;
                            counter_d = div_q;
                            state_d   = ST_STEP_HI;
                        end
                    end
                    MODE_HALT: ;
                    default: ;
                endcase
            end
            ST_RUN: begin
                if (toggle) begin
                    counter_d = div_q;
                    // Leaving RUN only at a phase boundary keeps every high phase full length.
                    if (mode_sel == MODE_RUN) begin
                        clk_out_d = ~clk_out_q;
                        tick_d    = ~clk_out_q;
                    end else begin
                        clk_out_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            ST_STEP_HI: begin
                if (toggle) begin
                    counter_d = div_q;
                    clk_out_d = 1'b0;
                    state_d   = ST_STEP_LO;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            ST_STEP_LO: begin
                if (toggle) begin
                    counter_d = div_q;
                    state_d   = ST_IDLE;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cnt_clr) begin
            edge_count_d = '0;
        end else if (tick_q) begin
            edge_count_d = edge_count_q + CYC_W'(1);
        end else begin
            edge_count_d = edge_count_q;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            div_q        <= CNT_W'(DEFAULT_DIV);
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            div_q        <= div_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign running    = (state_q != ST_IDLE);
    assign edge_count = edge_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_step_ctrl
// Purpose  : Directed self-checking bench for clk_step_ctrl (small parameters).
// Revision : 1.0
// ============================================================================
module tb_clk_step_ctrl;

    localparam logic [1:0] M_RUN  = 2'b00;
    localparam logic [1:0] M_HALT = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode_sel = M_HALT;
    logic       div_load = 1'b0;
    logic [3:0] div_val = '0;
    logic       step_key = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       clk_out;
    logic       tick;
    logic       running;
    logic [3:0] edge_count;

    int tests = 0;
    int fails = 0;

    clk_step_ctrl #(
        .CNT_W       (4),
        .DEFAULT_DIV (3),
        .DEB_CYCLES  (4),
        .CYC_W       (4)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .div_load   (div_load),
        .div_val    (div_val),
        .step_key   (step_key),
        .cnt_clr    (cnt_clr),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .edge_count (edge_count)
    );

    always #5 clkin = ~clkin;

    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        reset    = 1'b1;
        step_key = 1'b0;
        cnt_clr  = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        mode_sel = m;
        @(posedge clkin);
        @(posedge clkin);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        mode_sel = M_RUN;
        @(posedge clkin);
        #1;
        tests++;
        if (clk_out !== 1'b0 || tick !== 1'b0 || running !== 1'b0 || edge_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: clk_out=%b tick=%b running=%b edge=%0d, want 0 0 0 0",
                     clk_out, tick, running, edge_count);
        end
    endtask

    task automatic test_run();
        logic       exp_clk, exp_tick;
        logic [3:0] exp_edge;
        do_reset(M_RUN);
        for (int i = 1; i <= 21; i++) begin
            cyc();
            exp_clk  = (i >= 5) && (((i - 5) / 4) % 2 == 0);
            exp_tick = (i >= 5) && ((i - 5) % 8 == 0);
            exp_edge = (i <= 5) ? 4'd0 : 4'(((i - 6) / 8) + 1);
            tests++;
            if (clk_out !== exp_clk || tick !== exp_tick || edge_count !== exp_edge || running !== 1'b1) begin
                fails++;
                $display("FAIL run_cycle%0d: clk=%b tick=%b edge=%0d run=%b, want %b %b %0d 1",
                         i, clk_out, tick, edge_count, running, exp_clk, exp_tick, exp_edge);
            end
        end
    endtask

    task automatic test_halt();
        int bad;
        // Halt requested in the second cycle of the first high phase.
        do_reset(M_RUN);
        repeat (6) cyc();
        mode_sel = M_HALT;
        for (int i = 7; i <= 9; i++) begin
            cyc();
            tests++;
            if (clk_out !== (i < 9) || running !== (i < 9)) begin
                fails++;
                $display("FAIL halt_high_cycle%0d: clk=%b run=%b, want %b %b",
                         i, clk_out, running, (i < 9), (i < 9));
            end
        end
        bad = 0;
        repeat (10) begin
            cyc();
            if (clk_out !== 1'b0 || tick !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_high_after: %0d cycles with clk/tick high, want 0", bad);
        end
        // Halt requested during the first low phase.
        do_reset(M_RUN);
        repeat (10) cyc();
        mode_sel = M_HALT;
        bad = 0;
        repeat (10) begin
            cyc();
            if (clk_out !== 1'b0 || tick !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || running !== 1'b0 || edge_count !== 4'd1) begin
            fails++;
            $display("FAIL halt_low: bad=%0d run=%b edge=%0d, want 0 0 1", bad, running, edge_count);
        end
    endtask

    task automatic test_step();
        int ticks, highs, rise_at;
        do_reset(M_STEP);
        ticks = 0; highs = 0; rise_at = -1;
        for (int n = 1; n <= 30; n++) begin
            step_key = (n <= 10) && (n != 3);
            cyc();
            if (tick === 1'b1) begin
                ticks++;
                if (rise_at < 0) rise_at = n;
            end
            if (clk_out === 1'b1) highs++;
        end
        tests++;
        if (ticks != 1 || rise_at != 10 || highs != 4) begin
            fails++;
            $display("FAIL step_glitch: ticks=%0d rise_at=%0d highs=%0d, want 1 10 4",
                     ticks, rise_at, highs);
        end
        tests++;
        if (edge_count !== 4'd1 || running !== 1'b0 || clk_out !== 1'b0) begin
            fails++;
            $display("FAIL step_done: edge=%0d run=%b clk=%b, want 1 0 0", edge_count, running, clk_out);
        end
        ticks = 0;
        for (int n = 1; n <= 20; n++) begin
            step_key = (n <= 3);
            cyc();
            if (tick === 1'b1 || clk_out === 1'b1) ticks++;
        end
        tests++;
        if (ticks != 0 || edge_count !== 4'd1) begin
            fails++;
            $display("FAIL step_short: activity=%0d edge=%0d, want 0 1", ticks, edge_count);
        end
    endtask

    task automatic test_div_load();
        logic exp_clk, exp_tick, prev;
        do_reset(M_RUN);
        prev = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            div_load = (i == 7) || (i == 17);
            div_val  = (i == 7) ? 4'd1 : 4'd0;
            cyc();
            div_load = 1'b0;
            if (i >= 7) begin
                if (i <= 8)       exp_clk = 1'b1;
                else if (i <= 16) exp_clk = (((i - 9) / 2) % 2 == 1);
                else              exp_clk = (i >= 19) && (i % 2 == 1);
                exp_tick = exp_clk && !prev;
                prev     = exp_clk;
                tests++;
                if (clk_out !== exp_clk || tick !== exp_tick) begin
                    fails++;
                    $display("FAIL div_cycle%0d: clk=%b tick=%b, want %b %b",
                             i, clk_out, tick, exp_clk, exp_tick);
                end
            end
        end
    endtask

    task automatic test_edge_count();
        do_reset(M_HALT);
        div_load = 1'b1;
        div_val  = 4'd0;
        cyc();
        div_load = 1'b0;
        mode_sel = M_RUN;
        for (int k = 0; k < 80 && edge_count !== 4'd15; k++) cyc();
        tests++;
        if (edge_count !== 4'd15) begin
            fails++;
            $display("FAIL edge_reach15: edge=%0d, want 15", edge_count);
        end
        for (int k = 0; k < 10 && tick !== 1'b1; k++) cyc();
        cyc();
        tests++;
        if (edge_count !== 4'd0) begin
            fails++;
            $display("FAIL edge_wrap: edge=%0d, want 0", edge_count);
        end
        for (int k = 0; k < 10 && tick !== 1'b1; k++) cyc();
        cyc();
        for (int k = 0; k < 10 && tick !== 1'b1; k++) cyc();
        tests++;
        if (tick !== 1'b1 || edge_count !== 4'd1) begin
            fails++;
            $display("FAIL edge_pre_clr: tick=%b edge=%0d, want 1 1", tick, edge_count);
        end
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        tests++;
        if (edge_count !== 4'd0) begin
            fails++;
            $display("FAIL edge_clr_tick: edge=%0d, want 0", edge_count);
        end
        for (int k = 0; k < 10 && tick !== 1'b1; k++) cyc();
        cyc();
        tests++;
        if (edge_count !== 4'd1) begin
            fails++;
            $display("FAIL edge_resume: edge=%0d, want 1", edge_count);
        end
    endtask

    task automatic test_reset_mid_step();
        int highs;
        do_reset(M_RUN);
        repeat (8) cyc();
        mode_sel = M_STEP;
        for (int k = 0; k < 20 && running !== 1'b0; k++) cyc();
        step_key = 1'b1;
        for (int k = 0; k < 20 && tick !== 1'b1; k++) cyc();
        tests++;
        if (tick !== 1'b1 || clk_out !== 1'b1 || edge_count !== 4'd1) begin
            fails++;
            $display("FAIL rst_step_entry: tick=%b clk=%b edge=%0d, want 1 1 1", tick, clk_out, edge_count);
        end
        #2;
        reset    = 1'b1;
        step_key = 1'b0;
        #1;
        tests++;
        if (clk_out !== 1'b0 || tick !== 1'b0 || edge_count !== 4'd0 || running !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: clk=%b tick=%b edge=%0d run=%b, want 0 0 0 0",
                     clk_out, tick, edge_count, running);
        end
        @(posedge clkin);
        #1;
        reset = 1'b0;
        highs = 0;
        repeat (20) begin
            cyc();
            if (clk_out !== 1'b0 || tick !== 1'b0) highs++;
        end
        tests++;
        if (highs != 0) begin
            fails++;
            $display("FAIL rst_no_step: %0d active cycles, want 0", highs);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt();
        test_step();
        test_div_load();
        test_edge_count();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
